vga_frame_reader: RTL and testbench
===================================

# vga_frame_reader

Display-side reader for the 640x480 RGB444 frame buffer. Runs on the 25 MHz VGA pixel clock, which also drives the buffer's read port. Generates 640x480@60 Hz raster timing and the buffer read address/enable. Re-aligns the buffer's 1-cycle registered read data with delayed sync/blank, so pins get pixel, hsync, vsync and data-enable on the same edge.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- ADDR_W, 19, frame-buffer address width
- DATA_W, 12, pixel width, {R[11:8],G[7:4],B[3:0]}

Ports:
- clk  in  1  pixel clock, 25 MHz; also the buffer's rd_clk
- rst_n  in  1  synchronous active-low reset
- rd_en  out  1  buffer read enable
- rd_addr  out  ADDR_W  buffer read address
- fb_data  in  DATA_W  buffer read data; valid 1 clk after rd_en/rd_addr
- vga_r, vga_g, vga_b  out  4 each  pixel colour
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vga_de  out  1  active-video flag
- frame_start  out  1  1-clk pulse with output pixel (0,0)

## Operation
- Stage 0 counters:
  - h_cnt 0..H_TOTAL-1 (H_TOTAL=800); wraps to 0.
  - v_cnt 0..V_TOTAL-1 (V_TOTAL=525); increments when h_cnt wraps and wraps to 0 after 524.
- visible = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hs_raw low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
- vs_raw low for v_cnt in [490,491]. vs_raw is a function of v_cnt only.
- Address generation is incremental, with no multiplier:
  - pix_cnt increments on each visible cycle.
  - pix_cnt clears to 0 when (h_cnt,v_cnt) = (799,524).
  - Range 0..307199, never exceeded.
  - rd_addr = v_cnt*640 + h_cnt for every visible pixel.
- Stage 1 registers: rd_en <= visible; rd_addr <= pix_cnt. rd_addr holds its value during blanking.
- Delay line carries visible, hs_raw, vs_raw, and first = (h_cnt==0 && v_cnt==0) through 3 register stages.
- Stage 3 outputs:
  - {vga_r,vga_g,vga_b} <= delayed visible ? fb_data : 12'h000.
  - vga_de, vga_hs, vga_vs and frame_start come from the delay-line tap.
- Blanking: colour is forced to 0 whatever fb_data carries.
- Reset (synchronous, any time, including mid-frame), all values at the first clk edge with rst_n=0:
  - h_cnt=0, v_cnt=0, pix_cnt=0.
  - rd_en=0, rd_addr=0.
  - All delay stages inactive: visible 0, hs 1, vs 1, first 0.
  - Outputs: rgb=0, vga_de=0, vga_hs=1, vga_vs=1, frame_start=0.
- After release, counting restarts at (0,0). No partial-frame state survives.

## Timing
- Counter value (H,V) at edge n, then:
  - rd_addr/rd_en at edge n+1.
  - fb_data at edge n+2 (buffer latency).
  - Pins at edge n+3.
- Fixed latency 3 clks, applied identically to colour, de, hs, vs and frame_start. Sync-to-pixel relationship at the pins equals the raw counter relationship.
- First edge with rst_n=1 is counter cycle (0,0). At edge 1 rd_en=1, rd_addr=0. At edge 3 frame_start=1, vga_de=1, colour = data of address 0.
- Line period 800 clks; frame period 420000 clks (59.52 Hz at 25 MHz).
- Per line: 640 rd_en-high clks, contiguous. Per frame: 307200 reads; vertical blanking lines have zero reads.
- rd_en is never high while v_cnt >= 480 or h_cnt >= 640 (counter-stage view).

## Test plan
- Reset values: hold rst_n=0 for 5 clks with fb_data=12'hFFF -> rgb=0, de=0, hs=1, vs=1, rd_en=0, rd_addr=0, frame_start=0.
- Latency: release reset; model the buffer as data=addr[11:0] with 1-clk latency -> frame_start and de rise 3 clks after release; the first pixel at the pins is 12'h000, then 12'h001.
- Sync timing: over 2 frames, check:
  - hs low exactly 96 clks starting 656 clks after de rises.
  - de high 640 of every 800 clks on visible lines.
  - vs low exactly 1600 clks, starting 10 lines after the last visible line.
- Address sequence:
  - rd_addr 639 then 640 across the v0->v1 line boundary.
  - Last read 307199.
  - Next read after vertical blanking is 0.
  - Exactly 307200 rd_en pulses per frame.
- Blanking: drive fb_data=12'hABC constantly -> rgb=12'hABC only while de=1, 0 otherwise.
- Mid-frame reset: assert rst_n=0 for 1 clk at v_cnt=200, h_cnt=300 -> next edge shows reset values; the following frame_start occurs 3 clks after release; rd_addr restarts at 0.

Source files
------------

// File: rtl/vga_frame_reader.sv
// Display-side frame-buffer reader: 640x480@60 raster timing, linear read address
// generation, and a 3-stage alignment so colour, sync, de and frame_start reach the pins together.
module vga_frame_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] fb_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic              frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
  localparam int DEPTH    = 3;

  typedef struct packed {
    logic first;
    logic vs;
    logic hs;
    logic vis;
  } tap_t;

  localparam tap_t TAP_IDLE = '{first: 1'b0, vs: 1'b1, hs: 1'b1, vis: 1'b0};

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [ADDR_W-1:0] pix_cnt;
  logic              h_last;
  logic              v_last;
  logic              visible;
  tap_t              tap_in;
  tap_t              tap [DEPTH];
  logic [DATA_W-1:0] rgb;

  assign h_last  = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last  = (v_cnt == VW'(V_TOTAL - 1));
  assign visible = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));

  always_comb begin
    tap_in       = TAP_IDLE;
    tap_in.vis   = visible;
    tap_in.hs    = !((h_cnt >= HW'(HS_FIRST)) && (h_cnt <= HW'(HS_LAST)));
    tap_in.vs    = !((v_cnt >= VW'(VS_FIRST)) && (v_cnt <= VW'(VS_LAST)));
    tap_in.first = (h_cnt == '0) && (v_cnt == '0);
  end

  // Stage 0: raster counters plus a running pixel index that replaces v*H_ACTIVE+h.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      pix_cnt <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last)
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      if (h_last && v_last)
        pix_cnt <= '0;
      else if (visible)
        pix_cnt <= pix_cnt + 1'b1;
    end
  end

  // Stage 1: buffer request; the address only moves on visible cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_en <= visible;
      if (visible)
        rd_addr <= pix_cnt;
    end
  end

  // Timing taps travel alongside the read; tap[DEPTH-1] lines up with the registered colour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        tap[i] <= TAP_IDLE;
    end else begin
      tap[0] <= tap_in;
      for (int i = 1; i < DEPTH; i++)
        tap[i] <= tap[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rgb <= '0;
    else
      rgb <= tap[DEPTH-2].vis ? fb_data : '0;
  end

  assign vga_r       = rgb[11:8];
  assign vga_g       = rgb[7:4];
  assign vga_b       = rgb[3:0];
  assign vga_de      = tap[DEPTH-1].vis;
  assign vga_hs      = tap[DEPTH-1].hs;
  assign vga_vs      = tap[DEPTH-1].vs;
  assign frame_start = tap[DEPTH-1].first;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader using a shrunken raster (15x8 clocks/lines) so whole frames are cheap.
module tb_vga_frame_reader;

  localparam int H_ACT = 8, H_FP = 2, H_SY = 3, H_BP = 2;
  localparam int V_ACT = 4, V_FP = 1, V_SY = 2, V_BP = 1;
  localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en;
  logic [18:0] rd_addr;
  logic [11:0] fb_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de, frame_start;

  int          fb_sel = 2;   // 0: data = addr[11:0], 1: constant ABC, 2: constant FFF
  logic [11:0] mem_q = 12'h000;

  vga_frame_reader #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .ADDR_W(19), .DATA_W(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .fb_data(fb_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_de(vga_de), .frame_start(frame_start)
  );

  always #20 clk = ~clk;

  // Buffer model: registered read, one clock of latency.
  always @(posedge clk) if (rd_en) mem_q <= rd_addr[11:0];
  assign fb_data = (fb_sel == 1) ? 12'hABC : (fb_sel == 2) ? 12'hFFF : mem_q;

  typedef struct packed {
    logic [11:0] rgb;
    logic        de, hs, vs, fs;
  } pin_t;

  typedef struct {
    int          j;
    logic        en;
    int          addr;
    logic        de, hs, vs, fs;
    logic [11:0] rgb;
  } chk_t;

  localparam pin_t PIN_RST = '{rgb: 12'h000, de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  pin_t q[$];
  chk_t tbl[18];
  int   total = 0, bad = 0;
  int   j, m_h, m_v, hold_addr, rd_count;
  bit   table_on = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at j=%0d: got %0h expected %0h", name, j, act, exp);
    end
  endtask

  task automatic chk_reset_pins();
    chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
    chk("rst_de", int'(vga_de), 0);
    chk("rst_hs", int'(vga_hs), 1);
    chk("rst_vs", int'(vga_vs), 1);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
  endtask

  // Push the expectation for the counter state the DUT just sampled; pop the one due at the pins.
  task automatic step();
    pin_t e, p;
    logic vis;
    @(posedge clk); #1;
    j++;
    vis = (m_h < H_ACT) && (m_v < V_ACT);
    if (vis) hold_addr = m_v * H_ACT + m_h;
    chk("rd_en", int'(rd_en), int'(vis));
    chk("rd_addr", int'(rd_addr), hold_addr);
    if (rd_en) rd_count++;
    e.de  = vis;
    e.hs  = !((m_h >= H_ACT + H_FP) && (m_h < H_ACT + H_FP + H_SY));
    e.vs  = !((m_v >= V_ACT + V_FP) && (m_v < V_ACT + V_FP + V_SY));
    e.fs  = (m_h == 0) && (m_v == 0);
    e.rgb = !vis ? 12'h000 : (fb_sel == 1) ? 12'hABC : 12'(hold_addr);
    q.push_back(e);
    p = q.pop_front();
    chk("pin_rgb", int'({vga_r, vga_g, vga_b}), int'(p.rgb));
    chk("pin_de", int'(vga_de), int'(p.de));
    chk("pin_hs", int'(vga_hs), int'(p.hs));
    chk("pin_vs", int'(vga_vs), int'(p.vs));
    chk("pin_fs", int'(frame_start), int'(p.fs));
    if (table_on) begin
      for (int i = 0; i < 18; i++) begin
        if (tbl[i].j == j) begin
          chk("tbl_rd_en", int'(rd_en), int'(tbl[i].en));
          chk("tbl_rd_addr", int'(rd_addr), tbl[i].addr);
          chk("tbl_de", int'(vga_de), int'(tbl[i].de));
          chk("tbl_hs", int'(vga_hs), int'(tbl[i].hs));
          chk("tbl_vs", int'(vga_vs), int'(tbl[i].vs));
          chk("tbl_fs", int'(frame_start), int'(tbl[i].fs));
          chk("tbl_rgb", int'({vga_r, vga_g, vga_b}), int'(tbl[i].rgb));
          $display("table entry j=%0d checked: rd_en=%0b rd_addr=%0d de=%0b hs=%0b vs=%0b fs=%0b rgb=%03h",
                   j, rd_en, rd_addr, vga_de, vga_hs, vga_vs, frame_start, {vga_r, vga_g, vga_b});
        end
      end
    end
    m_h++;
    if (m_h == H_TOT) begin
      m_h = 0;
      m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk_reset_pins();
    $display("reset held %0d clks: rd_en=%0b rd_addr=%0d de=%0b hs=%0b vs=%0b", n, rd_en, rd_addr, vga_de, vga_hs, vga_vs);
    rst_n = 1'b1;
    q.delete();
    q.push_back(PIN_RST);
    q.push_back(PIN_RST);
    m_h = 0; m_v = 0; hold_addr = 0; j = 0; rd_count = 0;
  endtask

  initial begin
    // j = edges since release; rd_* reflect counter cycle j-1, pins reflect cycle j-3.
    tbl[0]  = '{1,   1'b1, 0,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
    tbl[1]  = '{3,   1'b1, 2,  1'b1, 1'b1, 1'b1, 1'b1, 12'h000};
    tbl[2]  = '{4,   1'b1, 3,  1'b1, 1'b1, 1'b1, 1'b0, 12'h001};
    tbl[3]  = '{8,   1'b1, 7,  1'b1, 1'b1, 1'b1, 1'b0, 12'h005};
    tbl[4]  = '{9,   1'b0, 7,  1'b1, 1'b1, 1'b1, 1'b0, 12'h006};
    tbl[5]  = '{12,  1'b0, 7,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
    tbl[6]  = '{13,  1'b0, 7,  1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
    tbl[7]  = '{15,  1'b0, 7,  1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
    tbl[8]  = '{16,  1'b1, 8,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
    tbl[9]  = '{19,  1'b1, 11, 1'b1, 1'b1, 1'b1, 1'b0, 12'h009};
    tbl[10] = '{53,  1'b1, 31, 1'b1, 1'b1, 1'b1, 1'b0, 12'h01D};
    tbl[11] = '{54,  1'b0, 31, 1'b1, 1'b1, 1'b1, 1'b0, 12'h01E};
    tbl[12] = '{77,  1'b0, 31, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
    tbl[13] = '{78,  1'b0, 31, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000};
    tbl[14] = '{107, 1'b0, 31, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000};
    tbl[15] = '{108, 1'b0, 31, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
    tbl[16] = '{121, 1'b1, 0,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
    tbl[17] = '{123, 1'b1, 2,  1'b1, 1'b1, 1'b1, 1'b1, 12'h000};

    // Reset with an all-ones buffer, then two full frames of addr-as-data.
    fb_sel = 2;
    do_reset(5);
    fb_sel = 0;
    table_on = 1;
    repeat (FRAME) step();
    chk("reads_frame1", rd_count, H_ACT * V_ACT);
    $display("frame 1: %0d rd_en pulses", rd_count);
    rd_count = 0;
    repeat (FRAME) step();
    chk("reads_frame2", rd_count, H_ACT * V_ACT);
    $display("frame 2: %0d rd_en pulses", rd_count);
    table_on = 0;

    // Constant buffer data must only reach the pins while de is high.
    fb_sel = 1;
    do_reset(2);
    repeat (FRAME) step();
    $display("blanking frame done, j=%0d", j);

    // Mid-frame reset at (h=5, v=2) of the second frame.
    fb_sel = 0;
    do_reset(2);
    repeat (FRAME) step();
    for (int n = 0; n < FRAME && !(m_h == 5 && m_v == 2); n++) step();
    chk("mid_reach", int'(m_h == 5 && m_v == 2), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_pins();
    $display("mid-frame reset: rd_en=%0b rd_addr=%0d de=%0b fs=%0b", rd_en, rd_addr, vga_de, frame_start);
    rst_n = 1'b1;
    q.delete();
    q.push_back(PIN_RST);
    q.push_back(PIN_RST);
    m_h = 0; m_v = 0; hold_addr = 0; j = 0; rd_count = 0;
    step();
    chk("mid_rd_addr0", int'(rd_addr), 0);
    chk("mid_rd_en", int'(rd_en), 1);
    step();
    chk("mid_fs_early", int'(frame_start), 0);
    step();
    chk("mid_fs", int'(frame_start), 1);
    $display("after mid-frame release: frame_start=%0b at j=%0d", frame_start, j);
    repeat (FRAME) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
